uart_tx_frame_serializer: RTL
=============================

// Module: uart_tx_frame_serializer
// PURPOSE
//  Upstream feeder for the 8N1 UART transmitter. Buffers FFT result words in a
//  small FIFO, splits each word into bytes (LSB first) and drives the TX byte
//  handshake (tx_data/tx_enable/tx_busy). Emits SYNC_BYTE before every frame of
//  FRAME_LEN words so the host can re-align the stream.
// PARAMETERS
//  WORD_BYTES  2      bytes per input word; word width = 8*WORD_BYTES
//  FIFO_DEPTH  16     word FIFO entries; power of two, >= 2
//  FRAME_LEN   64     words per frame, 1..65535
//  SYNC_BYTE   8'hA5  byte sent once before each frame
// PORTS
//  clk         in   1              system clock, single domain
//  rst         in   1              synchronous, active-high reset
//  in_data     in   8*WORD_BYTES   word to transmit
//  in_valid    in   1              in_data valid this cycle
//  in_ready    out  1              FIFO not full; word accepted when valid&ready
//  tx_data     out  8              byte to the UART transmitter
//  tx_enable   out  1              request to UART transmitter (level)
//  tx_busy     in   1              UART transmitter busy
//  fifo_count  out  log2(DEPTH)+1  words currently stored
//  overflow    out  1              sticky: in_valid seen while in_ready=0
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO emptied, fifo_count=0, in_ready=1,
//   tx_enable=0, tx_data=0, overflow=0, word/byte counters=0, state=IDLE.
//   Reset mid-byte drops tx_enable next cycle; the partial frame is discarded.
//  FIFO: write on in_valid&in_ready; read only in LOAD. Simultaneous
//   write+read leaves count unchanged; write while full ignored, sets overflow.
//   in_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
//  FSM:
//   IDLE      -> SYNC if fifo_count!=0 and word_cnt==0; -> LOAD if count!=0.
//   SYNC      tx_data<=SYNC_BYTE; -> REQ (return state LOAD).
//   LOAD      pop FIFO head into shift reg, byte_cnt<=0 -> REQ.
//   REQ       tx_enable=1; hold tx_data; on tx_busy=1 -> WAIT_DONE.
//   WAIT_DONE tx_enable=0; on tx_busy=0 -> NEXT.
//   NEXT      after sync byte -> LOAD. Else byte_cnt++, shift right 8;
//             if byte_cnt==WORD_BYTES-1: word_cnt++ (wraps to 0 at FRAME_LEN),
//             -> IDLE; else tx_data<=next byte -> REQ.
//  tx_data is registered and stable from entry into REQ until WAIT_DONE exits.
//  tx_enable is high only in REQ; deasserted the cycle after tx_busy seen high,
//   so the transmitter never sees a second request for one byte.
//  Byte order: in_data[7:0] first, in_data[8*WORD_BYTES-1 -: 8] last.
//  Frame wrap: word_cnt==FRAME_LEN-1 completing -> word_cnt=0, next word is
//   preceded by SYNC_BYTE. FIFO empty mid-frame: wait in IDLE, no sync resent.
//  Latency: first word into empty FIFO -> tx_enable high 3 cycles later
//   (IDLE->SYNC->REQ); no throughput limit beyond tx_busy.
// TESTING
//  T1 reset, push 16'h1234 -> bytes A5,34,12 on tx_data; fifo_count back to 0.
//  T2 FRAME_LEN=2, push 3 words -> A5,w0L,w0H,w1L,w1H,A5,w2L,w2H.
//  T3 push 17 words, tx_busy stuck 1 -> in_ready=0 at count 16, overflow=1.
//  T4 tx_busy delays 0..50 cycles -> exactly one tx_enable pulse per byte.
//  T5 rst asserted in WAIT_DONE -> tx_enable=0, count=0, next word gets A5.
//  T6 push+pop same cycle with count=5 -> count stays 5, data order intact.

Source files
------------

// File: rtl/uart_tx_frame_serializer.sv
// uart_tx_frame_serializer
// Buffers words in a small FIFO, splits each word into bytes (LSB first) and
// drives the byte handshake of the 8N1 UART transmitter. A sync byte is sent
// before the first word of every frame of FRAME_LEN words.
module uart_tx_frame_serializer #(
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 64,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [8*WORD_BYTES-1:0]     in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_enable,
    input  logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;
    localparam int BCW    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WCW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, SYNC, LOAD, REQ, WAIT_DONE, NEXT
    } state_t;

    state_t            state, state_nxt;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [BCW-1:0]    byte_cnt;
    logic [WCW-1:0]    word_cnt;
    logic              sync_sent;   // byte in flight is the sync byte, not word data
    logic              push, pop;
    logic              byte_last, frame_last;

    assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = in_valid & in_ready;
    assign byte_last  = (byte_cnt == BCW'(WORD_BYTES - 1));
    assign frame_last = (word_cnt == WCW'(FRAME_LEN - 1));
    assign shift_next = shift_reg >> 8;

    // FIFO storage; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; tx_enable is a pure decode of REQ so it drops the cycle
    // after the transmitter reports busy
    always_comb begin
        state_nxt = state;
        tx_enable = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) state_nxt = (word_cnt == '0) ? SYNC : LOAD;
            end
            SYNC: state_nxt = REQ;
            LOAD: begin
                pop       = 1'b1;
                state_nxt = REQ;
            end
            REQ: begin
                tx_enable = 1'b1;
                if (tx_busy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) state_nxt = NEXT;
            end
            NEXT: begin
                if (sync_sent)      state_nxt = LOAD;
                else if (byte_last) state_nxt = IDLE;
                else                state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte datapath: tx_data only changes on entry to REQ, so it is stable
    // for the whole REQ/WAIT_DONE handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data   <= 8'h00;
            shift_reg <= '0;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            sync_sent <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    tx_data   <= SYNC_BYTE;
                    sync_sent <= 1'b1;
                end
                LOAD: begin
                    shift_reg <= fifo_mem[rd_ptr];
                    tx_data   <= fifo_mem[rd_ptr][7:0];
                    byte_cnt  <= '0;
                    sync_sent <= 1'b0;
                end
                NEXT: begin
                    if (!sync_sent) begin
                        byte_cnt  <= byte_cnt + 1'b1;
                        shift_reg <= shift_next;
                        if (byte_last) word_cnt <= frame_last ? '0 : word_cnt + 1'b1;
                        else           tx_data  <= shift_next[7:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
